raw2rgb_track_overlay: RTL and testbench

RAW2RGB_TRACK_OVERLAY -- requirements
Module: raw2rgb_track_overlay

---
 rtl/raw2rgb_track_overlay.sv | 113 +++++++++++
 tb/tb_raw2rgb_track_overlay.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/raw2rgb_track_overlay.sv
// raw2rgb_track_overlay: 2x2 Bayer demosaic (2-cycle latency) with a frame-latched tracking box overlay.
// Define RAW2RGB_OUTLINE_EN to draw only the box outline instead of a filled box.
module raw2rgb_track_overlay #(
  parameter int DATA_W = 12,
  parameter int LINE_W = 640,
  parameter int CX_W = 10,
  parameter int CY_W = 9,
  parameter int BOX_HALF = 5,
  parameter logic [DATA_W-1:0] MARK_VAL = '1
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic [10:0]       iX_Cont,
  input  logic [10:0]       iY_Cont,
  input  logic [DATA_W-1:0] iDATA,
  input  logic              iDVAL,
  input  logic [CX_W-1:0]   iTRACK_X,
  input  logic [CY_W-1:0]   iTRACK_Y,
  input  logic              iTRACK_VALID,
  output logic [DATA_W-1:0] oRed,
  output logic [DATA_W-1:0] oGreen,
  output logic [DATA_W-1:0] oBlue,
  output logic              oDVAL
);
  localparam int AW = $clog2(LINE_W);
  localparam int XW = CX_W + 1;
  localparam int YW = CY_W + 1;
  logic [DATA_W-1:0] r_mem [LINE_W];
  logic [DATA_W-1:0] r_cur, r_left, r_above, r_al;
  logic [10:0] r_x1, r_y1;
  logic r_v1;
  logic [CX_W-1:0] r_tx;
  logic [CY_W-1:0] r_ty;
  logic r_tv;
  logic [XW-1:0] r_xlo, r_xhi;
  logic [YW-1:0] r_ylo, r_yhi;
  logic w_in, w_abv, w_load, w_tv, w_hx, w_hy, w_mark;
  logic [AW-1:0] w_addr;
  logic [CX_W-1:0] w_tx;
  logic [CY_W-1:0] w_ty;
  logic [1:0] w_par;
  logic [DATA_W-1:0] w_red, w_blue, w_green;
  logic [DATA_W:0] w_gsum;
  // Frame-start values bypass the shadow registers so the new track governs pixel (0,0) onward.
  always_comb begin
    w_in = 32'(iX_Cont) < 32'(LINE_W);
    w_abv = w_in && iY_Cont != '0;
    w_addr = iX_Cont[AW-1:0];
    w_load = iDVAL && iX_Cont == '0 && iY_Cont == '0;
    w_tx = w_load ? iTRACK_X : r_tx;
    w_ty = w_load ? iTRACK_Y : r_ty;
    w_tv = w_load ? iTRACK_VALID : r_tv;
    w_par = {r_y1[0], r_x1[0]};
    w_red = w_par == 2'b00 ? r_left : w_par == 2'b01 ? r_cur : w_par == 2'b10 ? r_al : r_above;
    w_blue = w_par == 2'b00 ? r_above : w_par == 2'b01 ? r_al : w_par == 2'b10 ? r_cur : r_left;
    w_gsum = r_x1[0] == r_y1[0] ? (DATA_W+1)'(r_cur) + (DATA_W+1)'(r_al)
                                : (DATA_W+1)'(r_left) + (DATA_W+1)'(r_above);
    w_green = DATA_W'(w_gsum >> 1);
    w_hx = 32'(r_x1) >= 32'(r_xlo) && 32'(r_x1) <= 32'(r_xhi);
    w_hy = 32'(r_y1) >= 32'(r_ylo) && 32'(r_y1) <= 32'(r_yhi);
`ifdef RAW2RGB_OUTLINE_EN
    w_mark = r_tv && w_hx && w_hy && (32'(r_x1) == 32'(r_xlo) || 32'(r_x1) == 32'(r_xhi) ||
                                      32'(r_y1) == 32'(r_ylo) || 32'(r_y1) == 32'(r_yhi));
`else
    w_mark = r_tv && w_hx && w_hy;
`endif
  end
  always_ff @(posedge iCLK)
    if (iDVAL && w_in) r_mem[w_addr] <= iDATA;
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_cur <= '0;
      r_left <= '0;
      r_above <= '0;
      r_al <= '0;
      r_x1 <= '0;
      r_y1 <= '0;
      r_v1 <= 1'b0;
      r_tx <= '0;
      r_ty <= '0;
      r_tv <= 1'b0;
      r_xlo <= '0;
      r_xhi <= '0;
      r_ylo <= '0;
      r_yhi <= '0;
      oDVAL <= 1'b0;
      oRed <= '0;
      oGreen <= '0;
      oBlue <= '0;
    end else begin
      r_v1 <= iDVAL;
      if (iDVAL) begin
        r_cur <= iDATA;
        r_left <= iX_Cont == '0 ? '0 : r_cur;
        r_above <= w_abv ? r_mem[w_addr] : '0;
        r_al <= (iX_Cont == '0 || !w_abv) ? '0 : r_above;
        r_x1 <= iX_Cont;
        r_y1 <= iY_Cont;
      end
      r_tx <= w_tx;
      r_ty <= w_ty;
      r_tv <= w_tv;
      r_xlo <= 32'(w_tx) >= 32'(BOX_HALF) ? XW'(w_tx) - XW'(BOX_HALF) : '0;
      r_xhi <= XW'(w_tx) + XW'(BOX_HALF);
      r_ylo <= 32'(w_ty) >= 32'(BOX_HALF) ? YW'(w_ty) - YW'(BOX_HALF) : '0;
      r_yhi <= YW'(w_ty) + YW'(BOX_HALF);
      oDVAL <= r_v1;
      oRed <= r_v1 ? (w_mark ? MARK_VAL : w_red) : '0;
      oGreen <= r_v1 ? (w_mark ? MARK_VAL : w_green) : '0;
      oBlue <= r_v1 ? (w_mark ? MARK_VAL : w_blue) : '0;
    end
  end
endmodule

// File: tb/tb_raw2rgb_track_overlay.sv
// tb_raw2rgb_track_overlay: random and directed frames checked against a window/parity reference model.
module tb_raw2rgb_track_overlay;
  localparam int LW = 16;
  localparam int H = 5;
  logic iCLK = 0, iRST = 1, iDVAL = 0, iTRACK_VALID = 0;
  logic [10:0] iX_Cont = 0, iY_Cont = 0;
  logic [11:0] iDATA = 0, oRed, oGreen, oBlue;
  logic [9:0] iTRACK_X = 0;
  logic [8:0] iTRACK_Y = 0;
  logic oDVAL;
  int n_chk = 0, n_pass = 0;
  int img [32][32];
  int mtx = 0, mty = 0;
  bit mtv = 0;
  typedef struct { bit v; int x; int y; logic [35:0] rgb; } exp_t;
  exp_t q[$];
  bit have, ev;
  int ex, ey;
  logic [36:0] got, want;

  raw2rgb_track_overlay #(.LINE_W(LW)) dut (
    .iCLK(iCLK), .iRST(iRST), .iX_Cont(iX_Cont), .iY_Cont(iY_Cont), .iDATA(iDATA),
    .iDVAL(iDVAL), .iTRACK_X(iTRACK_X), .iTRACK_Y(iTRACK_Y), .iTRACK_VALID(iTRACK_VALID),
    .oRed(oRed), .oGreen(oGreen), .oBlue(oBlue), .oDVAL(oDVAL)
  );

  always #5 iCLK = ~iCLK;

  function automatic int pix(int xx, int yy, int x, int y);
    if (xx < 0 || yy < 0) return 0;
    if (yy < y && x >= LW) return 0;
    return img[yy][xx];
  endfunction

  // Picks R/B/G from whichever window position has that colour's Bayer parity.
  function automatic exp_t model(int x, int y);
    exp_t n;
    int gs, s, xl, xh, yl, yh;
    logic [11:0] r, b;
    bit mk;
    gs = 0; r = 0; b = 0;
    for (int dy = -1; dy <= 0; dy++)
      for (int dx = -1; dx <= 0; dx++) begin
        s = pix(x + dx, y + dy, x, y);
        if (((x + dx) & 1) == 1 && ((y + dy) & 1) == 0) r = 12'(s);
        else if (((x + dx) & 1) == 0 && ((y + dy) & 1) == 1) b = 12'(s);
        else gs += s;
      end
    xl = (mtx - H < 0) ? 0 : mtx - H;
    xh = mtx + H;
    yl = (mty - H < 0) ? 0 : mty - H;
    yh = mty + H;
    mk = mtv && x >= xl && x <= xh && y >= yl && y <= yh;
`ifdef RAW2RGB_OUTLINE_EN
    mk = mk && (x == xl || x == xh || y == yl || y == yh);
`endif
    n.v = 1; n.x = x; n.y = y;
    n.rgb = mk ? {3{12'hFFF}} : {r, 12'(gs / 2), b};
    return n;
  endfunction

  task automatic drive(input bit rst, input bit v, input int x, input int y, input int d,
                       input int tx, input int ty, input bit tv);
    exp_t n;
    @(negedge iCLK);
    got = {oDVAL, oRed, oGreen, oBlue};
    have = q.size() == 2;
    if (have) begin
      n = q.pop_front();
      ev = n.v; ex = n.x; ey = n.y;
      want = n.v ? {1'b1, n.rgb} : '0;
    end
    iRST = rst; iDVAL = v; iX_Cont = 11'(x); iY_Cont = 11'(y); iDATA = 12'(d);
    iTRACK_X = 10'(tx); iTRACK_Y = 9'(ty); iTRACK_VALID = tv;
    n.v = 0; n.x = x; n.y = y; n.rgb = '0;
    if (rst) begin
      foreach (q[i]) q[i].v = 0;
      mtv = 0; mtx = 0; mty = 0;
    end else if (v) begin
      img[y][x] = d & 'hFFF;
      if (x == 0 && y == 0) begin mtx = tx; mty = ty; mtv = tv; end
      n = model(x, y);
    end
    q.push_back(n);
  endtask

  task automatic test_reset;
    for (int i = 0; i < 6; i++) begin
      drive(i < 3, i < 3, i, 0, $urandom_range(4095), 0, 0, 1);
      if (i >= 1) begin
        n_chk++;
        if (got !== '0) $display("FAIL reset cyc%0d got=%h want=0", i, got); else n_pass++;
      end
    end
  endtask

  task automatic test_flat;
    for (int i = 0; i < 12 * 6 + 2; i++) begin
      if (i < 72) drive(0, 1, i % 12, i / 12, 'h100, 3, 3, 0);
      else drive(0, 0, 0, 0, 0, 0, 0, 0);
      if (have) begin
        n_chk++;
        if (got !== want) $display("FAIL flat (%0d,%0d) got=%h want=%h", ex, ey, got, want); else n_pass++;
      end
      if (have && ev && ex >= 1 && ey >= 1) begin
        n_chk++;
        if (got !== {1'b1, {3{12'h100}}}) $display("FAIL flat_const (%0d,%0d) got=%h want=1100100100", ex, ey, got);
        else n_pass++;
      end
    end
  endtask

  task automatic test_vector;
    int x, y, d;
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 18; i++) begin
        x = i % 4; y = i / 4; d = $urandom_range(4095);
        if (x == 2 && y == 2) d = f ? 'hFFF : 'h400;
        if (x == 3 && y == 2) d = 'h080;
        if (x == 2 && y == 3) d = 'h010;
        if (x == 3 && y == 3) d = f ? 'hFFF : 'h200;
        if (i < 16) drive(0, 1, x, y, d, 0, 0, 0); else drive(0, 0, 0, 0, 0, 0, 0, 0);
        if (have) begin
          n_chk++;
          if (got !== want) $display("FAIL vector (%0d,%0d) got=%h want=%h", ex, ey, got, want); else n_pass++;
        end
        if (have && ev && ex == 3 && ey == 3 && f == 0) begin
          n_chk++;
          if (got !== {1'b1, 12'h080, 12'h300, 12'h010}) $display("FAIL vec33 got=%h want=1080300010", got);
          else n_pass++;
        end
        if (have && ev && ex == 3 && ey == 3 && f == 1) begin
          n_chk++;
          if (got[23:12] !== 12'hFFF) $display("FAIL green_sat got=%h want=fff", got[23:12]); else n_pass++;
        end
      end
  endtask

  task automatic test_marker;
    for (int i = 0; i < 12 * 10 + 2; i++) begin
      if (i < 120) drive(0, 1, i % 12, i / 12, $urandom_range(4094), 2, 2, 1);
      else drive(0, 0, 0, 0, 0, 0, 0, 0);
      if (have) begin
        n_chk++;
        if (got !== want) $display("FAIL marker (%0d,%0d) got=%h want=%h", ex, ey, got, want); else n_pass++;
      end
`ifdef RAW2RGB_OUTLINE_EN
      if (have && ev && ex == 7 && ey == 3) begin
`else
      if (have && ev && ex <= 7 && ey <= 7) begin
`endif
        n_chk++;
        if (got !== {1'b1, {3{12'hFFF}}}) $display("FAIL mark_const (%0d,%0d) got=%h want=1ffffffff", ex, ey, got);
        else n_pass++;
      end
    end
  endtask

  task automatic test_track_move;
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 14 * 10 + 2; i++) begin
        if (i < 140) drive(0, 1, i % 14, i / 14, $urandom_range(4094), (f == 0 && i / 14 < 5) ? 4 : 10, 3, 1);
        else drive(0, 0, 0, 0, 0, 0, 0, 0);
        if (have) begin
          n_chk++;
          if (got !== want) $display("FAIL track_move f%0d (%0d,%0d) got=%h want=%h", f, ex, ey, got, want);
          else n_pass++;
        end
      end
  endtask

  task automatic test_random;
    bit gap;
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < 98; i++) begin
        gap = i < 96 && $urandom_range(3) == 0;
        if (i >= 96 || gap) drive(0, 0, 0, 0, 0, 0, 0, 0);
        else drive(0, 1, i % 12, i / 12, $urandom_range(4095), $urandom_range(15), $urandom_range(9), 1'($urandom_range(1)));
        if (have) begin
          n_chk++;
          if (got !== want) $display("FAIL random (%0d,%0d) got=%h want=%h", ex, ey, got, want); else n_pass++;
        end
        if (gap) i--;
      end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 3 * 12 + 6; i++) begin
      drive(0, 1, i % 12, i / 12, $urandom_range(4094), 5, 2, 1);
      if (have) begin
        n_chk++;
        if (got !== want) $display("FAIL pre_rst (%0d,%0d) got=%h want=%h", ex, ey, got, want); else n_pass++;
      end
    end
    drive(1, 1, 6, 3, $urandom_range(4094), 5, 2, 1);
    for (int k = 0; k < 2; k++) begin
      drive(0, 0, 0, 0, 0, 5, 2, 1);
      n_chk++;
      if (got !== '0) $display("FAIL rst_mid cyc%0d got=%h want=0", k, got); else n_pass++;
    end
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 12 * 4 + 2; i++) begin
        if (i < 48) drive(0, 1, i % 12, i / 12, $urandom_range(4094), 5, 2, f == 1);
        else drive(0, 0, 0, 0, 0, 5, 2, 1);
        if (have) begin
          n_chk++;
          if (got !== want) $display("FAIL post_rst f%0d (%0d,%0d) got=%h want=%h", f, ex, ey, got, want);
          else n_pass++;
        end
      end
  endtask

  task automatic test_offimage;
    for (int i = 0; i < 20 * 4 + 2; i++) begin
      if (i < 80) drive(0, 1, i % 20, i / 20, $urandom_range(4095), 0, 0, 0);
      else drive(0, 0, 0, 0, 0, 0, 0, 0);
      if (have) begin
        n_chk++;
        if (got !== want) $display("FAIL offimage (%0d,%0d) got=%h want=%h", ex, ey, got, want); else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset;
    test_flat;
    test_vector;
    test_marker;
    test_track_move;
    test_random;
    test_reset_mid;
    test_offimage;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
